mem_port_arbiter: RTL

//  Shares one single-port memory between CPU instruction fetch, CPU load/store and the ML

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Build option MEM_ARB_TIMEOUT_EN is consumed by mem_port_arbiter.
package mem_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  localparam int REQ_IFETCH = 0;
  localparam int REQ_DATA   = 1;
  localparam int REQ_ACCEL  = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after last (cyclic), one-hot grant.
// Ports: req vector, last winner id -> grant one-hot and its index.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N_REQ = 3,
  localparam int IW    = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_id
);

  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last) + off) % N_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-port memory between ifetch, LSU and accel DMA.
// Ports: per-requester valid/ready + rsp pulses; mem req/gnt/rvalid; busy.
// Build option MEM_ARB_TIMEOUT_EN adds the response timeout and DRAIN state.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*AW-1:0]     req_addr,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*DW-1:0]     req_wdata,
  input  logic [N_REQ*(DW/8)-1:0] req_be,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic [AW-1:0]           mem_addr,
  output logic                    mem_we,
  output logic [DW-1:0]           mem_wdata,
  output logic [DW/8-1:0]         mem_be,
  input  logic                    mem_rvalid,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    busy
);

  localparam int BW = DW / 8;
  localparam int IW = id_width(N_REQ);

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t            state_q;
  state_t            state_d;
  logic [IW-1:0]     last_q;
  logic [IW-1:0]     owner_q;
  logic [IW-1:0]     grant_id;
  logic [N_REQ-1:0]  grant;
  logic              idle;
  logic              accept;
  logic              rsp_load;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req     (req_valid),
    .last    (last_q),
    .grant   (grant),
    .grant_id(grant_id)
  );

  assign idle = (state_q == IDLE);
  // rst gates the handshake so nothing is taken while reset is held.
  assign accept    = idle && rst && (|req_valid);
  assign req_ready = accept ? grant : '0;
  assign mem_req   = (state_q == ISSUE);
  assign busy      = !idle;
  assign rsp_load  = (state_q == WAIT) && mem_rvalid;

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] tmo_cnt;
  logic          tmo;
  logic          tmo_rsp;
  logic          drain_q;
  logic          rsp_err_q;

  // Counts cycles since the first mem_req, across ISSUE and WAIT.
  assign tmo = ((state_q == ISSUE) || (state_q == WAIT)) &&
               (tmo_cnt == CW'(TIMEOUT_CYC - 1));
  // A grant or response landing on the last cycle still wins.
  assign tmo_rsp = tmo && !(mem_req ? mem_gnt : mem_rvalid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err_q <= 1'b0;
      drain_q   <= 1'b0;
    end else begin
      if (rsp_load) begin
        rsp_rdata <= mem_rdata;
        rsp_err_q <= 1'b0;
      end else if (tmo_rsp) begin
        rsp_rdata <= '0;
        rsp_err_q <= 1'b1;
      end
      // Memory already granted: its late response must be swallowed.
      if (tmo_rsp && !mem_req) begin
        drain_q <= 1'b1;
      end else if (state_q == RESP) begin
        drain_q <= 1'b0;
      end
    end
  end

  assign rsp_err = rsp_err_q;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
    end else if (rsp_load) begin
      rsp_rdata <= mem_rdata;
    end
  end

  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
      ISSUE: begin
        if (mem_gnt)  state_d = WAIT;
        else if (tmo) state_d = RESP;
      end
      WAIT:  if (mem_rvalid || tmo) state_d = RESP;
      RESP:  state_d = drain_q ? DRAIN : IDLE;
      DRAIN: if (mem_rvalid) state_d = IDLE;
`else
      ISSUE: if (mem_gnt) state_d = WAIT;
      WAIT:  if (mem_rvalid) state_d = RESP;
      RESP:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_be    <= '0;
      owner_q   <= '0;
      last_q    <= IW'(N_REQ - 1);
    end else if (accept) begin
      mem_addr  <= req_addr[grant_id*AW +: AW];
      mem_we    <= req_we[grant_id];
      mem_wdata <= req_wdata[grant_id*DW +: DW];
      mem_be    <= req_be[grant_id*BW +: BW];
      owner_q   <= grant_id;
      last_q    <= grant_id;
    end
  end

endmodule
